// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
//   Shared RISC-V register-file constants and types. The register file,
//   decode and the write scoreboard all use these, so address widths cannot
//   drift apart between blocks.
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : rv_pkg

// File: rtl/sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
//   Pending-write counter for one architectural register. It counts up when
//   an instruction writing this register issues, and counts down when writeback
//   commits the write.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset, clears the count
//   inc             an issue targeting this register was accepted
//   dec             writeback is committing a write to this register
//   nonzero         at least one write is outstanding
//   full            count is at its maximum; further issues must stall
//   underflow_pulse a retire arrived while nothing was outstanding
// -----------------------------------------------------------------------------
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic full,
    output logic underflow_pulse
);

    logic [CNT_W-1:0] cnt;

    assign nonzero         = |cnt;
    assign full            = &cnt;
    // A retire with nothing outstanding is a bookkeeping error. It is flagged
    // even when an issue lands in the same cycle, because that retire cannot
    // belong to the new issue.
    assign underflow_pulse = dec & ~nonzero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            unique case ({inc, dec})
                2'b10: if (!full)   cnt <= cnt + 1'b1;  // guard; stall already blocks this
                2'b01: if (nonzero) cnt <= cnt - 1'b1;  // hold at zero on underflow
                default: cnt <= cnt;                    // idle, or issue+retire cancel
            endcase
        end
    end

endmodule : sb_counter

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Tracks register writes that are in flight between decode and writeback.
//   An instruction is stalled while any source register it reads still has an
//   outstanding write, or while its destination counter is saturated. The
//   register file has no write-through. A retire therefore clears the hazard
//   only on the cycle after the write edge, and this happens naturally because
//   the hazard check reads the registered counters.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   issue_*              instruction presented by decode (rd / rs1 / rs2 + enables)
//   flush_i              redirect; the instruction in decode is cancelled
//   retire_valid_i/rd_i  writeback commit (same as regfile rd_wren / rd_addr)
//   stall_o              decode must hold
//   issue_ack_o          issue accepted this cycle
//   busy_o               any write outstanding
//   pending_o            per-register outstanding flag (bit 0 always 0)
//   underflow_err_o      sticky: retire seen for a register with nothing pending
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  issue_rd_en_i,
    input  logic [REG_ADDR_W-1:0] issue_rs1_i,
    input  logic                  issue_rs1_en_i,
    input  logic [REG_ADDR_W-1:0] issue_rs2_i,
    input  logic                  issue_rs2_en_i,
    input  logic                  flush_i,
    input  logic                  retire_valid_i,
    input  logic [REG_ADDR_W-1:0] retire_rd_i,
    output logic                  stall_o,
    output logic                  issue_ack_o,
    output logic                  busy_o,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic                  underflow_err_o
);

    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] underflow;
    logic                raw1, raw2, waw_full;

    // x0 is hardwired zero and is never tracked.
    assign nonzero[0]   = 1'b0;
    assign full[0]      = 1'b0;
    assign underflow[0] = 1'b0;

    generate
        for (genvar n = 1; n < NUM_REGS; n++) begin : g_cnt
            logic inc, dec;
            assign inc = issue_ack_o & issue_rd_en_i & (issue_rd_i == reg_addr_t'(n));
            assign dec = retire_valid_i & (retire_rd_i == reg_addr_t'(n));

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk             (clk_i),
                .rst_n           (rst_ni),
                .inc             (inc),
                .dec             (dec),
                .nonzero         (nonzero[n]),
                .full            (full[n]),
                .underflow_pulse (underflow[n])
            );
        end
    endgenerate

    // The hazard check uses only registered state. A same-cycle retire does not
    // bypass it, and an instruction whose rs equals its rd does not see its
    // own increment.
    assign raw1     = issue_rs1_en_i & nonzero[issue_rs1_i];
    assign raw2     = issue_rs2_en_i & nonzero[issue_rs2_i];
    assign waw_full = issue_rd_en_i  & full[issue_rd_i];

    assign stall_o     = issue_valid_i & (raw1 | raw2 | waw_full);
    // Nothing may be accepted while reset is held, even if decode is driving valid.
    assign issue_ack_o = rst_ni & issue_valid_i & ~stall_o & ~flush_i;

    assign pending_o = nonzero;
    assign busy_o    = |nonzero;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underflow_err_o <= 1'b0;
        end else if (|underflow) begin
            underflow_err_o <= 1'b1;
        end
    end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed vectors with hand-computed expectations. Each vector drives the
//   inputs just after a rising edge and queues the outputs expected for that
//   cycle. A separate monitor pops the queue on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, rd_en = 1'b0, rs1_en = 1'b0, rs2_en = 1'b0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, ret_rd = '0;
    logic        flush = 1'b0, ret_v = 1'b0;
    logic        stall, ack, busy, err;
    logic [31:0] pend;

    typedef struct packed {
        logic        stall;
        logic        ack;
        logic        busy;
        logic [31:0] pend;
        logic        err;
    } obs_t;

    obs_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   vid  = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.CNT_W(2)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .issue_valid_i   (valid),
        .issue_rd_i      (rd),
        .issue_rd_en_i   (rd_en),
        .issue_rs1_i     (rs1),
        .issue_rs1_en_i  (rs1_en),
        .issue_rs2_i     (rs2),
        .issue_rs2_en_i  (rs2_en),
        .flush_i         (flush),
        .retire_valid_i  (ret_v),
        .retire_rd_i     (ret_rd),
        .stall_o         (stall),
        .issue_ack_o     (ack),
        .busy_o          (busy),
        .pending_o       (pend),
        .underflow_err_o (err)
    );

    // Monitor: compare against the head of the queue at mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{stall: stall, ack: ack, busy: busy, pend: pend, err: err};
            nvec++;
            if (a !== e) begin
                nerr++;
                $display("FAIL vec%0d: got stall=%b ack=%b busy=%b pend=%h err=%b, want stall=%b ack=%b busy=%b pend=%h err=%b",
                         nvec, a.stall, a.ack, a.busy, a.pend, a.err,
                         e.stall, e.ack, e.busy, e.pend, e.err);
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] d, input logic de,
                         input logic [4:0] s1, input logic s1e,
                         input logic fl, input logic rv, input logic [4:0] rr);
        valid = v; rd = d; rd_en = de; rs1 = s1; rs1_en = s1e;
        rs2 = 5'd0; rs2_en = 1'b0; flush = fl; ret_v = rv; ret_rd = rr;
    endtask

    task automatic expect_out(input logic s, input logic a, input logic [31:0] p, input logic e);
        obs_t x;
        x = '{stall: s, ack: a, busy: (p != 32'h0), pend: p, err: e};
        exp_q.push_back(x);
    endtask

    // One cycle: issue(v,rd,rd_en,rs1,rs1_en), flush, retire(rv,rr) -> expected outputs
    task automatic vec(input logic v, input logic [4:0] d, input logic de,
                       input logic [4:0] s1, input logic s1e,
                       input logic fl, input logic rv, input logic [4:0] rr,
                       input logic es, input logic ea, input logic [31:0] ep, input logic ee);
        @(posedge clk); #1;
        drive(v, d, de, s1, s1e, fl, rv, rr);
        expect_out(es, ea, ep, ee);
        vid++;
    endtask

    task automatic idle(input logic [31:0] ep, input logic ee);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep, ee);
    endtask

    initial begin
        // Reset state, with decode driving an issue request while reset is held.
        @(posedge clk); #1;
        drive(1, 5'd2, 1, 5'd5, 1, 0, 0, 0);
        expect_out(0, 0, 32'h0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        idle(32'h0, 0);
        vec(1, 5'd0, 0, 5'd5, 1, 0, 0, 0,   0, 1, 32'h0, 0);          // rs1=5, nothing pending

        // RAW on x3: the retire does not clear the stall in its own cycle
        vec(1, 5'd3, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h0, 0);
        vec(1, 5'd0, 0, 5'd3, 1, 0, 0, 0,   1, 0, 32'h8, 0);
        vec(1, 5'd0, 0, 5'd3, 1, 0, 1, 5'd3, 1, 0, 32'h8, 0);
        vec(1, 5'd0, 0, 5'd3, 1, 0, 0, 0,   0, 1, 32'h0, 0);

        // WAW saturation on x7 (max 3 outstanding)
        vec(1, 5'd7, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h0, 0);
        vec(1, 5'd7, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h80, 0);
        vec(1, 5'd7, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h80, 0);
        vec(1, 5'd7, 1, 5'd0, 0, 0, 0, 0,   1, 0, 32'h80, 0);         // count 3 -> full
        vec(1, 5'd7, 1, 5'd0, 0, 0, 1, 5'd7, 1, 0, 32'h80, 0);       // retire not yet visible
        vec(1, 5'd7, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h80, 0);         // count 2 -> accepted, back to 3
        vec(0, 0, 0, 0, 0, 0, 1, 5'd7,      0, 0, 32'h80, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 5'd7,      0, 0, 32'h80, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 5'd7,      0, 0, 32'h80, 0);
        idle(32'h0, 0);

        // Simultaneous issue and retire on x4 with count 1: count stays at 1
        vec(1, 5'd4, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h0, 0);
        vec(1, 5'd4, 1, 5'd0, 0, 0, 1, 5'd4, 0, 1, 32'h10, 0);
        idle(32'h10, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 5'd4,      0, 0, 32'h10, 0);
        idle(32'h0, 0);

        // Flush cancels the issue of rd=9
        vec(1, 5'd9, 1, 5'd0, 0, 1, 0, 0,   0, 0, 32'h0, 0);
        idle(32'h0, 0);

        // x0 is untracked: issue rd=0/rs1=0, then retire rd=0 without underflow
        vec(1, 5'd0, 1, 5'd0, 1, 0, 0, 0,   0, 1, 32'h0, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 5'd0,      0, 0, 32'h0, 0);
        idle(32'h0, 0);

        // rs1 == rd does not stall on its own issue
        vec(1, 5'd6, 1, 5'd6, 1, 0, 0, 0,   0, 1, 32'h0, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 5'd6,      0, 0, 32'h40, 0);
        idle(32'h0, 0);

        // Underflow on x12: the error is registered and sticky
        vec(0, 0, 0, 0, 0, 0, 1, 5'd12,     0, 0, 32'h0, 0);
        idle(32'h0, 1);
        idle(32'h0, 1);

        // Build pending = 0x108, then apply reset asynchronously mid-cycle
        vec(1, 5'd3, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h0, 1);
        vec(1, 5'd8, 1, 5'd0, 0, 0, 0, 0,   0, 1, 32'h8, 1);
        vec(1, 5'd0, 0, 5'd3, 1, 0, 0, 0,   1, 0, 32'h108, 1);
        @(posedge clk); #1;
        drive(1, 5'd0, 0, 5'd3, 1, 0, 0, 0);
        #1 rst_n = 1'b0;
        expect_out(0, 0, 32'h0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(32'h0, 0);

        // Drain the queue within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish, got %0d vectors, want %0d", nvec, vid);
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_scoreboard

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks in-flight register writes between the decode stage (reader side of the register file) and writeback (writer side, `rd_wren`/`rd_addr`).
- Keeps a small pending-write counter per architectural register.
- Stalls issue of any instruction whose source registers still have outstanding writes.
- The regfile has no write-through, so a value written at a clock edge is readable only afterwards; the scoreboard enforces that timing.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max outstanding writes per register = 2^CNT_W - 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  decode has an instruction presenting for issue this cycle.
- issue_rd_i  in  5  destination register of the issuing instruction.
- issue_rd_en_i  in  1  issuing instruction writes rd.
- issue_rs1_i  in  5  source register 1.
- issue_rs1_en_i  in  1  instruction reads rs1.
- issue_rs2_i  in  5  source register 2.
- issue_rs2_en_i  in  1  instruction reads rs2.
- flush_i  in  1  branch/jump redirect; cancels the instruction currently in decode.
- retire_valid_i  in  1  writeback commits a register write (same signal as regfile `rd_wren`).
- retire_rd_i  in  5  register being written (same as regfile `rd_addr`).
- stall_o  out  1  decode must hold; issue is not accepted.
- issue_ack_o  out  1  issue accepted this cycle.
- busy_o  out  1  at least one register has a pending write.
- pending_o  out  32  bit n = 1 when the counter for register n is nonzero.
- underflow_err_o  out  1  sticky: a retire arrived for a register with zero pending writes.

Behaviour:
- Reset (async, rst_ni=0):
  - all counters 0; underflow_err_o=0.
  - stall_o, issue_ack_o, busy_o, pending_o all 0 (combinational from cleared state).
- Register x0:
  - never tracked; counter 0 is constant 0.
  - rs==0 never causes a stall; rd==0 issue/retire are ignored and never flag underflow.
- Hazard (combinational, same cycle):
  - raw1 = issue_rs1_en_i & pending(rs1).
  - raw2 = issue_rs2_en_i & pending(rs2).
  - waw_full = issue_rd_en_i & counter(rd) == max.
  - stall_o = issue_valid_i & (raw1 | raw2 | waw_full).
- Issue acceptance: issue_ack_o = issue_valid_i & ~stall_o & ~flush_i. Flush takes priority; a flushed instruction never increments.
- Counter update at posedge, per register n:
  - inc = issue_ack_o & issue_rd_en_i & issue_rd_i==n & n!=0.
  - dec = retire_valid_i & retire_rd_i==n & n!=0.
  - inc&dec: unchanged. inc only: +1. dec only: −1.
  - dec with counter 0: counter stays 0, underflow_err_o sets and stays 1 until reset.
- No write-through:
  - a retire to register r does not clear a stall on r in the same cycle.
  - stall drops the following cycle, when the regfile holds the new value.
- An issue whose rs equals its own rd is checked against pending state before the increment, so it does not self-stall.
- Latency:
  - hazard decision is 0-cycle combinational.
  - counter/pending_o update is 1 cycle after the event edge.
- Reset mid-operation:
  - all pending state is lost immediately.
  - the pipeline is reset simultaneously, so no retires for prior issues follow.
- Width rules:
  - counters are unsigned CNT_W bits, never wrap; saturation is prevented by waw_full.
  - busy_o = OR of pending_o.

Decomposition:
- Shared package `rv_pkg` (add if absent): NUM_REGS=32, REG_ADDR_W=5, typedef `reg_addr_t` = logic [4:0].
- One sub-module `sb_counter`:
  - a CNT_W up/down counter with inc, dec, and async reset.
  - outputs nonzero, full, underflow_pulse.
  - instantiated 31 times (x1..x31) in a generate loop.
- Hazard logic, ack, and error flag live in the top module.

Test Plan:
- Reset then idle: all outputs 0; issue rs1=5 (en) with nothing pending -> stall_o=0, issue_ack_o=1.
- RAW stall:
  - issue rd=3 -> pending_o[3]=1 next cycle.
  - next issue rs1=3 -> stall_o=1.
  - retire rd=3 -> stall_o still 1 that cycle, 0 the following cycle, pending_o[3]=0.
- WAW saturation (CNT_W=2): three issues rd=7 accepted -> fourth issue rd=7 gives stall_o=1; one retire rd=7 -> issue accepted next cycle.
- Simultaneous issue and retire:
  - setup: counter[4]=1.
  - issue rd=4 and retire rd=4 same cycle -> counter stays 1, pending_o[4]=1.
- Flush:
  - issue_valid_i=1, rd=9, flush_i=1 -> issue_ack_o=0, pending_o[9] stays 0.
  - x0: issue rd=0 and rs1=0 -> no stall, pending_o=0.
- Underflow and async reset:
  - retire rd=12 with nothing pending -> underflow_err_o=1, sticky.
  - assert rst_ni=0 mid-clock with pending_o=0x0000_0108 -> all outputs 0 immediately, without waiting for a clock edge.
